// File: rtl/lut_layer_pkg.sv
// Shared types and helpers for the LUT-neuron layer sequencer.
// The slice helper works on a maximum-width connection word so one function serves every parameterisation.
package lut_layer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic CFG_SEL_TT   = 1'b0;
    localparam logic CFG_SEL_CONN = 1'b1;

    localparam int MAX_CONN_W = 64;
    localparam int MAX_IDX_W  = 8;

    // Connection index k lives at [k*idx_w +: idx_w]; bits past the word end read as 0.
    function automatic logic [MAX_IDX_W-1:0] conn_slice(input logic [MAX_CONN_W-1:0] word,
                                                        input int k,
                                                        input int idx_w);
        logic [MAX_IDX_W-1:0] s;
        s = '0;
        for (int b = 0; b < MAX_IDX_W; b++) begin
            if (b < idx_w && (k * idx_w + b) < MAX_CONN_W) begin
                s[b] = word[k * idx_w + b];
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/lut_layer_sequencer_if.sv
// Input, output and configuration handshakes of the layer sequencer.
// The slave modport is the sequencer side; the master modport is the surrounding datapath.
interface lut_layer_sequencer_if #(
    parameter int IN_W      = 64,
    parameter int N_NEURONS = 32,
    parameter int FANIN     = 6
) ();
    logic                         in_valid;
    logic                         in_ready;
    logic [IN_W-1:0]              in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [N_NEURONS-1:0]         out_data;
    logic                         cfg_valid;
    logic                         cfg_ready;
    logic                         cfg_sel;
    logic [$clog2(N_NEURONS)-1:0] cfg_neuron;
    logic [(2**FANIN)-1:0]        cfg_data;

    modport slave (
        input  in_valid, in_data, out_ready, cfg_valid, cfg_sel, cfg_neuron, cfg_data,
        output in_ready, out_valid, out_data, cfg_ready
    );

    modport master (
        output in_valid, in_data, out_ready, cfg_valid, cfg_sel, cfg_neuron, cfg_data,
        input  in_ready, out_valid, out_data, cfg_ready
    );
endinterface

// File: rtl/lut_neuron_eval.sv
// Combinational evaluation of one FANIN-input LUT neuron.
// Shared by every neuron of the layer; the sequencer feeds it one neuron's tables per cycle.
module lut_neuron_eval
    import lut_layer_pkg::*;
#(
    parameter int IN_W  = 64,
    parameter int FANIN = 6,
    parameter int IDX_W = $clog2(IN_W)
) (
    input  logic [IN_W-1:0]       x,
    input  logic [(2**FANIN)-1:0] conn,
    input  logic [(2**FANIN)-1:0] tt,
    output logic                  y
);
    logic [MAX_CONN_W-1:0] conn_ext;
    logic [MAX_IDX_W-1:0]  idx;
    logic [FANIN-1:0]      addr;

    assign conn_ext = MAX_CONN_W'(conn);

    // Indices that fall outside the input vector select bit 0.
    always_comb begin
        idx  = '0;
        addr = '0;
        for (int k = 0; k < FANIN; k++) begin
            idx = conn_slice(conn_ext, k, IDX_W);
            if (int'(idx) < IN_W) begin
                addr[k] = x[idx[IDX_W-1:0]];
            end else begin
                addr[k] = x[0];
            end
        end
    end

    assign y = tt[addr];

endmodule

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed LUT-neuron layer: one neuron evaluated per cycle from writable
// connection and truth tables, full output vector presented with a valid/ready handshake.
//
// state | meaning
// IDLE  | accepts table writes (priority) or a new input vector
// RUN   | evaluates neuron[cnt] each cycle into out_data[cnt]
// DONE  | out_valid held until the consumer takes the vector
module lut_layer_sequencer
    import lut_layer_pkg::*;
#(
    parameter int IN_W      = 64,
    parameter int N_NEURONS = 32,
    parameter int FANIN     = 6,
    parameter int IDX_W     = $clog2(IN_W)
) (
    input  logic                  clk,
    input  logic                  rst,
    lut_layer_sequencer_if.slave  bus,
    output logic                  busy
);
    localparam int CNT_W = $clog2(N_NEURONS);
    localparam int TT_W  = 2**FANIN;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IN_W-1:0]      x_q, x_d;
    logic [N_NEURONS-1:0] out_data_q, out_data_d;
    logic                 cfg_we;
    logic                 neuron_y;

    // Tables are deliberately left out of reset so a sequencer reset keeps the loaded layer.
    logic [TT_W-1:0]      conn_tbl [N_NEURONS];
    logic [TT_W-1:0]      tt_tbl   [N_NEURONS];

    lut_neuron_eval #(
        .IN_W  (IN_W),
        .FANIN (FANIN),
        .IDX_W (IDX_W)
    ) u_eval (
        .x    (x_q),
        .conn (conn_tbl[cnt_q]),
        .tt   (tt_tbl[cnt_q]),
        .y    (neuron_y)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        x_d          = x_q;
        out_data_d   = out_data_q;
        cfg_we       = 1'b0;
        bus.in_ready  = 1'b0;
        bus.cfg_ready = 1'b0;
        case (state_q)
            IDLE: begin
                bus.cfg_ready = 1'b1;
                bus.in_ready  = !bus.cfg_valid;
                if (bus.cfg_valid) begin
                    cfg_we = 1'b1;
                end else if (bus.in_valid) begin
                    x_d     = bus.in_data;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                out_data_d[cnt_q] = neuron_y;
                cnt_d             = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N_NEURONS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            x_q        <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            out_data_q <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_we) begin
            if (bus.cfg_sel == CFG_SEL_CONN) begin
                conn_tbl[bus.cfg_neuron] <= bus.cfg_data;
            end else begin
                tt_tbl[bus.cfg_neuron] <= bus.cfg_data;
            end
        end
    end

    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = out_data_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Directed bench for lut_layer_sequencer: table loading, evaluation, backpressure,
// config/input priority and mid-run reset, with hand-computed expected vectors.
module tb_lut_layer_sequencer;

    localparam int IN_W      = 64;
    localparam int N_NEURONS = 32;
    localparam int FANIN     = 6;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    lut_layer_sequencer_if #(.IN_W(IN_W), .N_NEURONS(N_NEURONS), .FANIN(FANIN)) bus ();

    lut_layer_sequencer #(.IN_W(IN_W), .N_NEURONS(N_NEURONS), .FANIN(FANIN)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    task automatic cfg_write(input logic sel, input logic [4:0] n, input logic [63:0] d);
        int k;
        @(negedge clk);
        bus.cfg_valid = 1'b1; bus.cfg_sel = sel; bus.cfg_neuron = n; bus.cfg_data = d;
        #1;
        k = 0;
        while (!bus.cfg_ready && k < 50) begin
            @(negedge clk); #1; k++;
        end
        tests++;
        if (!bus.cfg_ready) begin
            fails++; $display("FAIL cfg_write_timeout neuron=%0d cfg_ready=%b required 1", n, bus.cfg_ready);
        end
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic start_vector(input logic [63:0] v);
        int k;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = v;
        #1;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk); #1; k++;
        end
        tests++;
        if (!bus.in_ready) begin
            fails++; $display("FAIL start_timeout in_ready=%b required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk); lat++;
        end
    endtask

    task automatic drain();
        @(negedge clk); bus.out_ready = 1'b1;
        @(negedge clk); bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        tests++; if (bus.out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got %h exp 0", bus.out_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        tests++; if (bus.cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_cfg_ready got %b exp 1", bus.cfg_ready); end
    endtask

    task automatic test_and();
        int lat;
        cfg_write(1'b1, 5'd0, 64'h0000_0000_0000_0245);  // slot0=5, slot1=9
        cfg_write(1'b0, 5'd0, 64'h8888_8888_8888_8888);
        start_vector(64'h0000_0000_0000_0220);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL and_busy got %b exp 1", busy); end
        wait_out(lat);
        tests++; if (lat !== 32) begin fails++; $display("FAIL and_latency got %0d exp 32", lat); end
        tests++; if (bus.out_data[0] !== 1'b1) begin fails++; $display("FAIL and_both_set got %b exp 1", bus.out_data[0]); end
        drain();
        start_vector(64'h0000_0000_0000_0020);
        wait_out(lat);
        tests++; if (bus.out_data[0] !== 1'b0) begin fails++; $display("FAIL and_one_set got %b exp 0", bus.out_data[0]); end
        drain();
    endtask

    task automatic test_identity();
        int lat;
        for (int n = 0; n < N_NEURONS; n++) begin
            cfg_write(1'b1, 5'(n), 64'(n));
            cfg_write(1'b0, 5'(n), 64'hAAAA_AAAA_AAAA_AAAA);
        end
        start_vector(64'h0000_0000_F0F0_1234);
        wait_out(lat);
        tests++; if (lat !== 32) begin fails++; $display("FAIL ident_latency got %0d exp 32", lat); end
        tests++; if (bus.out_data !== 32'hF0F0_1234) begin fails++; $display("FAIL ident_vec1 got %h exp f0f01234", bus.out_data); end
        drain();
        start_vector(64'hFFFF_FFFF_0000_0001);
        wait_out(lat);
        tests++; if (bus.out_data !== 32'h0000_0001) begin fails++; $display("FAIL ident_vec2 got %h exp 00000001", bus.out_data); end
        drain();
    endtask

    task automatic test_done_stall();
        int lat;
        start_vector(64'h0000_0000_A5A5_5A5A);
        wait_out(lat);
        bus.cfg_valid = 1'b1; bus.cfg_sel = 1'b1; bus.cfg_neuron = 5'd31; bus.cfg_data = 64'h0;
        for (int i = 0; i < 10; i++) begin
            #1;
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA5A5_5A5A || bus.in_ready !== 1'b0 || bus.cfg_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_cycle%0d valid=%b data=%h in_ready=%b cfg_ready=%b exp 1 a5a55a5a 0 0",
                         i, bus.out_valid, bus.out_data, bus.in_ready, bus.cfg_ready);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL stall_release_valid got %b exp 0", bus.out_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stall_release_busy got %b exp 0", busy); end
        tests++; if (bus.cfg_ready !== 1'b1) begin fails++; $display("FAIL stall_release_cfg_ready got %b exp 1", bus.cfg_ready); end
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        // Neuron 31 now follows x[0] instead of x[31].
        start_vector(64'h0000_0000_0000_0001);
        wait_out(lat);
        tests++; if (bus.out_data !== 32'h8000_0001) begin fails++; $display("FAIL stall_cfg_applied got %h exp 80000001", bus.out_data); end
        drain();
    endtask

    task automatic test_cfg_priority();
        int lat;
        @(negedge clk);
        bus.cfg_valid = 1'b1; bus.cfg_sel = 1'b0; bus.cfg_neuron = 5'd31; bus.cfg_data = 64'h5555_5555_5555_5555;
        bus.in_valid = 1'b1; bus.in_data = 64'h0000_0000_1234_5678;
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL prio_in_ready got %b exp 0", bus.in_ready); end
        tests++; if (bus.cfg_ready !== 1'b1) begin fails++; $display("FAIL prio_cfg_ready got %b exp 1", bus.cfg_ready); end
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL prio_not_started got busy=%b exp 0", busy); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL prio_in_ready_next got %b exp 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL prio_accepted got busy=%b exp 1", busy); end
        wait_out(lat);
        tests++; if (lat !== 32) begin fails++; $display("FAIL prio_latency got %0d exp 32", lat); end
        tests++; if (bus.out_data !== 32'h9234_5678) begin fails++; $display("FAIL prio_data got %h exp 92345678", bus.out_data); end
        drain();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        start_vector(64'h0000_0000_FFFF_FFFF);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b exp 0", busy); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got %b exp 0", bus.out_valid); end
        tests++; if (bus.out_data !== 32'h0) begin fails++; $display("FAIL midrst_out_data got %h exp 0", bus.out_data); end
        start_vector(64'h0000_0000_0F0F_F0F1);
        wait_out(lat);
        tests++; if (lat !== 32) begin fails++; $display("FAIL midrst_latency got %0d exp 32", lat); end
        tests++; if (bus.out_data !== 32'h0F0F_F0F1) begin fails++; $display("FAIL midrst_fresh got %h exp 0f0ff0f1", bus.out_data); end
        drain();
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        bus.cfg_valid  = 1'b0;
        bus.cfg_sel    = 1'b0;
        bus.cfg_neuron = '0;
        bus.cfg_data   = '0;
        test_reset();
        test_and();
        test_identity();
        test_done_stall();
        test_cfg_priority();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lut_layer_sequencer.md
Name: lut_layer_sequencer

Overview:
- Time-multiplexed evaluator for one quantized LUT-neuron layer. Each neuron is a FANIN-input, 1-output truth table.
- The block holds the layer in writable tables: a per-neuron connection table and a per-neuron truth table.
- It accepts one input activation vector, evaluates one neuron per cycle, and returns the full output vector.
- Sits between the previous layer's output register and the next layer, as the runtime-reconfigurable replacement for hard-wired per-neuron ROMs.

Parameters:
- IN_W, 64, width of input activation vector.
- N_NEURONS, 32, neurons in the layer (width of output vector).
- FANIN, 6, inputs per neuron. Truth-table depth is 2**FANIN.
- IDX_W, $clog2(IN_W), width of one connection index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept input vector.
- in_data  in  IN_W  input activation bits.
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  N_NEURONS  neuron outputs; bit n = neuron n.
- cfg_valid  in  1  table write request.
- cfg_ready  out  1  write accepted this cycle.
- cfg_sel  in  1  0 = truth table, 1 = connection table.
- cfg_neuron  in  $clog2(N_NEURONS)  target neuron.
- cfg_data  in  2**FANIN  truth table, or packed indices (index k at [k*IDX_W +: IDX_W]; upper bits ignored).
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: state=IDLE, out_valid=0, out_data=0, neuron counter=0. cfg_ready and in_ready are combinational from state.
- Tables are not reset: contents are preserved across rst and are X after power-up. They must be configured before use.
- Address rule: for neuron n, address bit k = x[conn[n][k]], where x is the latched input. Output = tt[n][address]. Bit 0 of the truth table corresponds to address 0.
- States:
  - IDLE: cfg_ready = cfg_valid is not needed; cfg_ready = 1. in_ready = !cfg_valid.
  - IDLE with cfg_valid: write the selected table entry at the edge; stay IDLE. Config has priority over input in the same cycle; in_ready=0 that cycle.
  - IDLE with in_valid && in_ready: latch in_data, counter=0, go to RUN.
  - RUN: each cycle, compute neuron[counter] combinationally from the latched input and the table reads. Register the result into out_data[counter]; counter++.
  - RUN at counter == N_NEURONS-1: go to DONE and set out_valid=1.
  - RUN: cfg_ready=0 and in_ready=0.
  - DONE: out_valid=1 and out_data stable until out_ready. On out_valid && out_ready, clear out_valid and go to IDLE. out_data holds its last value.
- Latency: input accepted at edge t → out_valid high after edge t+N_NEURONS. Throughput is one vector per N_NEURONS+2 cycles minimum (accept, N evaluations, drain handshake); no overlap.
- out_data bits not yet evaluated in RUN keep their previous-vector values. Consumers use out_data only while out_valid=1.
- Out-of-range indices: connection indices >= IN_W read bit 0 of the input.
- rst asserted mid-RUN or in DONE: abort to IDLE next edge, out_valid=0, out_data=0; tables untouched.
- Writes from cfg_valid while not in IDLE are held off (cfg_ready=0). The requester keeps the request stable until accepted.

Decomposition:
- Package lut_layer_pkg: state enum (IDLE, RUN, DONE), CFG_SEL_TT=0 / CFG_SEL_CONN=1 constants, and the packed-connection slice helper function.
- One sub-module: lut_neuron_eval (combinational). It takes the latched input, a connection word and a truth-table word, and returns 1 output bit. Instantiated once and shared across all neurons.

Test Plan:
- Reset → out_valid=0, out_data=0, busy=0, in_ready=1, cfg_ready=1.
- Configure neuron 0 as AND: conn = {5,9 in slots 0,1; others 0}, tt = 64'h8888_8888_8888_8888. Input with bits 5,9 set → out_data[0]=1. Input with only bit 5 set → out_data[0]=0. out_valid rises exactly N_NEURONS=32 cycles after the accepting edge.
- Load all 32 neurons as identity of input n (conn slot 0 = n, tt = 64'hAAAA_AAAA_AAAA_AAAA). Input 64'h0000_0000_F0F0_1234 → out_data=32'hF0F0_1234.
- Hold out_ready=0 for 10 cycles in DONE → out_valid and out_data stable, in_ready=0, a cfg write is stalled (cfg_ready=0). Raise out_ready → IDLE next cycle and the pending cfg write is accepted.
- cfg_valid and in_valid together in IDLE → cfg write completes first (in_ready=0 that cycle); input is accepted the following cycle.
- Assert rst at RUN counter=15 → IDLE, out_valid=0, out_data=0 next cycle. A fresh vector then evaluates correctly with the previously loaded tables.
